// File: rtl/max_search_23x23_pkg.sv
// Shared types and defaults for the output-map maximum search block.
package max_search_23x23_pkg;

    localparam int ADDR_W   = 13;
    localparam int DATA_W   = 32;
    localparam int COLS_DEF = 81;
    localparam int ROWS_DEF = 81;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_REPORT,
        ST_WAIT,
        ST_MASK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/max_search_23x23_om_mask_walker.sv
// Emits one clipped, row-major zero-write address per cycle over a MASK_W x MASK_H box.
// Latency: first write the cycle after start; no backpressure, done marks the last write.
module max_search_23x23_om_mask_walker
    import max_search_23x23_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int MASK_W = 23,
    parameter int MASK_H = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] anchor_row,
    input  logic [ADDR_W-1:0] anchor_col,
    input  logic [ADDR_W-1:0] anchor_addr,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] MW_M1   = ADDR_W'(MASK_W - 1);
    localparam logic [ADDR_W-1:0] MH_M1   = ADDR_W'(MASK_H - 1);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    logic              busy;
    logic [ADDR_W-1:0] cur_row;
    logic [ADDR_W-1:0] cur_col;
    logic [ADDR_W-1:0] col_first;
    logic [ADDR_W-1:0] row_last;
    logic [ADDR_W-1:0] col_last;
    logic [ADDR_W-1:0] line_addr;
    logic [ADDR_W-1:0] row_end;
    logic [ADDR_W-1:0] col_end;

    // Clip the box to the map edge so off-map cells cost neither a write nor a cycle.
    always_comb begin
        row_end = anchor_row + MH_M1;
        col_end = anchor_col + MW_M1;
        if (row_end > ROW_MAX) row_end = ROW_MAX;
        if (col_end > COL_MAX) col_end = COL_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            cur_row   <= '0;
            cur_col   <= '0;
            col_first <= '0;
            row_last  <= '0;
            col_last  <= '0;
            line_addr <= '0;
            addr      <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cur_row   <= anchor_row;
            cur_col   <= anchor_col;
            col_first <= anchor_col;
            row_last  <= row_end;
            col_last  <= col_end;
            line_addr <= anchor_addr;
            addr      <= anchor_addr;
        end else if (busy) begin
            if (cur_col == col_last) begin
                if (cur_row == row_last) begin
                    busy <= 1'b0;
                end else begin
                    // Next line starts one full map row below the previous line start.
                    cur_row   <= cur_row + ONE;
                    cur_col   <= col_first;
                    line_addr <= line_addr + COLS_A;
                    addr      <= line_addr + COLS_A;
                end
            end else begin
                cur_col <= cur_col + ONE;
                addr    <= addr + ONE;
            end
        end
    end

    assign wr   = busy;
    assign done = busy && (cur_col == col_last) && (cur_row == row_last);

endmodule

// File: rtl/max_search_23x23.sv
// Raster-scans the output map for its maximum, reports it, masks accepted faces and rescans.
// Latency: report COLS*ROWS+RD_LAT cycles after scan entry; no backpressure, waits for iEnd/iFace_ready.
module max_search_23x23
    import max_search_23x23_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int MASK_W    = 23,
    parameter int MASK_H    = 23,
    parameter int MAX_FACES = 16,
    parameter int RD_LAT    = 1
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic [31:0] iData_from_OM,
    input  logic        iFace_ready,
    input  logic        iEnd,
    output logic [12:0] oAddr_OM,
    output logic        oWr_OM,
    output logic [31:0] oData_to_OM,
    output logic [12:0] oPosition,
    output logic [31:0] oMax_val,
    output logic        oOutput_ready,
    output logic        oFinish
);

    localparam int FC_W = $clog2(MAX_FACES + 1);
    localparam int DW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COL_MAX   = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(MAX_FACES - 1);
    localparam logic [DW-1:0]     DRAIN_END = DW'(RD_LAT - 1);

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] scan_row;
    logic [ADDR_W-1:0] scan_col;

    logic              pipe_vld  [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];
    logic [ADDR_W-1:0] pipe_row  [RD_LAT];
    logic [ADDR_W-1:0] pipe_col  [RD_LAT];

    logic [DATA_W-1:0] max_val;
    logic [ADDR_W-1:0] max_addr;
    logic [ADDR_W-1:0] max_row;
    logic [ADDR_W-1:0] max_col;
    logic [DW-1:0]     drain_cnt;
    logic [FC_W-1:0]   face_cnt;

    logic              hit;
    logic              mask_start;
    logic              mask_wr;
    logic              mask_done;
    logic [ADDR_W-1:0] mask_addr;

    // Strictly greater keeps the lowest address on ties because the scan ascends.
    assign hit = pipe_vld[RD_LAT-1] && (iData_from_OM > max_val);

    always_comb begin
        next_state = state;
        mask_start = 1'b0;
        unique case (state)
            ST_IDLE:   if (iStart) next_state = ST_SCAN;
            ST_SCAN:   if (scan_addr == LAST_A) next_state = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt == DRAIN_END) next_state = ST_REPORT;
            ST_REPORT: next_state = ST_WAIT;
            ST_WAIT: begin
                if (iEnd) begin
                    next_state = ST_DONE;
                end else if (iFace_ready) begin
                    if (face_cnt == FC_LAST) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_MASK;
                        mask_start = 1'b1;
                    end
                end
            end
            ST_MASK:   if (mask_done) next_state = ST_SCAN;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state     <= ST_IDLE;
            scan_addr <= '0;
            scan_row  <= '0;
            scan_col  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_row[i]  <= '0;
                pipe_col[i]  <= '0;
            end
            max_val   <= '0;
            max_addr  <= '0;
            max_row   <= '0;
            max_col   <= '0;
            drain_cnt <= '0;
            face_cnt  <= '0;
            oPosition <= '0;
            oMax_val  <= '0;
        end else begin
            state <= next_state;

            // Tag each read with its coordinates so returning data can be attributed.
            pipe_vld[0]  <= (state == ST_SCAN);
            pipe_addr[0] <= scan_addr;
            pipe_row[0]  <= scan_row;
            pipe_col[0]  <= scan_col;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_row[i]  <= pipe_row[i-1];
                pipe_col[i]  <= pipe_col[i-1];
            end

            if (state != ST_SCAN && next_state == ST_SCAN) begin
                scan_addr <= '0;
                scan_row  <= '0;
                scan_col  <= '0;
                max_val   <= '0;
                max_addr  <= '0;
                max_row   <= '0;
                max_col   <= '0;
            end else begin
                if (state == ST_SCAN && scan_addr != LAST_A) begin
                    scan_addr <= scan_addr + ONE;
                    if (scan_col == COL_MAX) begin
                        scan_col <= '0;
                        scan_row <= scan_row + ONE;
                    end else begin
                        scan_col <= scan_col + ONE;
                    end
                end
                if (hit) begin
                    max_val  <= iData_from_OM;
                    max_addr <= pipe_addr[RD_LAT-1];
                    max_row  <= pipe_row[RD_LAT-1];
                    max_col  <= pipe_col[RD_LAT-1];
                end
            end

            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;

            // The final compare lands in the last drain cycle, so fold it in here.
            if (next_state == ST_REPORT) begin
                oPosition <= hit ? pipe_addr[RD_LAT-1] : max_addr;
                oMax_val  <= hit ? iData_from_OM : max_val;
            end

            if (state == ST_DONE) begin
                face_cnt <= '0;
            end else if (state == ST_WAIT && !iEnd && iFace_ready) begin
                face_cnt <= face_cnt + FC_W'(1);
            end
        end
    end

    max_search_23x23_om_mask_walker #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .MASK_W (MASK_W),
        .MASK_H (MASK_H)
    ) u_mask_walker (
        .clk         (iClk),
        .rst_n       (iReset_n),
        .start       (mask_start),
        .anchor_row  (max_row),
        .anchor_col  (max_col),
        .anchor_addr (max_addr),
        .wr          (mask_wr),
        .addr        (mask_addr),
        .done        (mask_done)
    );

    assign oWr_OM        = mask_wr && (state == ST_MASK);
    assign oAddr_OM      = (state == ST_MASK) ? mask_addr : scan_addr;
    assign oData_to_OM   = '0;
    assign oOutput_ready = (state == ST_REPORT);
    assign oFinish       = (state == ST_DONE);

endmodule

// File: tb/tb_max_search_23x23.sv
// Directed bench for max_search_23x23 against a one-cycle-latency OM memory model.
module tb_max_search_23x23;

    localparam int NC = 81;

    logic        iClk = 1'b0;
    logic        iReset_n;
    logic        iStart;
    logic [31:0] iData_from_OM;
    logic        iFace_ready;
    logic        iEnd;
    logic [12:0] oAddr_OM;
    logic        oWr_OM;
    logic [31:0] oData_to_OM;
    logic [12:0] oPosition;
    logic [31:0] oMax_val;
    logic        oOutput_ready;
    logic        oFinish;

    max_search_23x23 dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iStart        (iStart),
        .iData_from_OM (iData_from_OM),
        .iFace_ready   (iFace_ready),
        .iEnd          (iEnd),
        .oAddr_OM      (oAddr_OM),
        .oWr_OM        (oWr_OM),
        .oData_to_OM   (oData_to_OM),
        .oPosition     (oPosition),
        .oMax_val      (oMax_val),
        .oOutput_ready (oOutput_ready),
        .oFinish       (oFinish)
    );

    always #5 iClk = ~iClk;

    logic [31:0] om [0:8191];

    always @(posedge iClk) begin
        iData_from_OM <= om[oAddr_OM];
        if (oWr_OM) om[oAddr_OM] = oData_to_OM;
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_cnt, wr_bad, rep_cnt, rep_cyc, fin_cnt, fin_cyc;
    int box_r0, box_c0, box_r1, box_c1;
    int t0, resp_cyc;
    logic [31:0] rep_pos, rep_max;

    always @(posedge iClk) cyc++;

    always @(negedge iClk) begin
        if (oWr_OM) begin
            int r, c;
            wr_cnt++;
            r = int'(oAddr_OM) / NC;
            c = int'(oAddr_OM) % NC;
            if (oData_to_OM != 32'd0) wr_bad++;
            if (r < box_r0 || r > box_r1 || c < box_c0 || c > box_c1) wr_bad++;
        end
        if (oOutput_ready) begin
            rep_cnt++;
            rep_cyc = cyc;
            rep_pos = {19'd0, oPosition};
            rep_max = oMax_val;
        end
        if (oFinish) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic new_test(input int r0, input int c0, input int r1, input int c1);
        for (int i = 0; i < 8192; i++) om[i] = 32'd0;
        wr_cnt = 0; wr_bad = 0; rep_cnt = 0; fin_cnt = 0;
        box_r0 = r0; box_c0 = c0; box_r1 = r1; box_c1 = c1;
    endtask

    task automatic start_frame();
        iStart = 1'b1;
        t0 = cyc;
        tick(1);
        iStart = 1'b0;
    endtask

    task automatic wait_report(input string tag, input int exp_cnt);
        int n;
        n = 0;
        while (rep_cnt < exp_cnt && n < 20000) begin
            tick(1);
            n++;
        end
        if (rep_cnt < exp_cnt) chk({tag, "_timeout"}, rep_cnt, exp_cnt);
    endtask

    task automatic respond(input logic face, input logic fin);
        resp_cyc = cyc;
        iFace_ready = face;
        iEnd = fin;
        tick(1);
        iFace_ready = 1'b0;
        iEnd = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        respond(1'b0, 1'b1);
        tick(4);
        chk({tag, "_fin_cnt"}, fin_cnt, 1);
        chk({tag, "_fin_cyc"}, fin_cyc, resp_cyc + 1);
    endtask

    initial begin
        iReset_n = 1'b0;
        iStart = 1'b0;
        iFace_ready = 1'b0;
        iEnd = 1'b0;
        new_test(0, 0, -1, -1);
        tick(3);
        chk("rst_addr", {19'd0, oAddr_OM}, 0);
        chk("rst_wr_rdy_fin", {29'd0, oWr_OM, oOutput_ready, oFinish}, 0);
        chk("rst_pos", {19'd0, oPosition}, 0);
        chk("rst_max", oMax_val, 0);
        iReset_n = 1'b1;
        tick(2);

        // 1: single peak, exact report timing, iEnd finishes without writes
        new_test(0, 0, -1, -1);
        om[500] = 32'h0500_0000;
        start_frame();
        wait_report("t1", 1);
        chk("t1_lat", rep_cyc - t0, 6563);
        chk("t1_pos", rep_pos, 500);
        chk("t1_max", rep_max, 32'h0500_0000);
        end_frame("t1");
        chk("t1_rep_cnt", rep_cnt, 1);
        chk("t1_wr_cnt", wr_cnt, 0);

        // 2: tie keeps the lower address
        new_test(0, 0, -1, -1);
        om[10] = 32'h100;
        om[4000] = 32'h100;
        start_frame();
        wait_report("t2", 1);
        chk("t2_pos", rep_pos, 10);
        chk("t2_max", rep_max, 32'h100);
        end_frame("t2");

        // 3: mask clipped at right and bottom edges, no wrap into next row
        new_test(70, 75, 80, 80);
        om[5745] = 32'h900;
        om[6153] = 32'h850;
        om[100]  = 32'h800;
        om[5751] = 32'h7FF;
        start_frame();
        wait_report("t3a", 1);
        chk("t3_pos1", rep_pos, 5745);
        chk("t3_max1", rep_max, 32'h900);
        respond(1'b1, 1'b0);
        wait_report("t3b", 2);
        chk("t3_wr_cnt", wr_cnt, 66);
        chk("t3_wr_bad", wr_bad, 0);
        chk("t3_pos2", rep_pos, 100);
        chk("t3_max2", rep_max, 32'h800);
        chk("t3_nowrap", om[5751], 32'h7FF);
        chk("t3_zeroed", om[6153], 0);
        end_frame("t3");

        // 4: full 23x23 mask at the origin
        new_test(0, 0, 22, 22);
        om[0]    = 32'hFFFF_FFFF;
        om[1804] = 32'hAAA;
        om[23]   = 32'h555;
        om[1863] = 32'h444;
        start_frame();
        wait_report("t4a", 1);
        chk("t4_pos1", rep_pos, 0);
        chk("t4_max1", rep_max, 32'hFFFF_FFFF);
        respond(1'b1, 1'b0);
        wait_report("t4b", 2);
        chk("t4_wr_cnt", wr_cnt, 529);
        chk("t4_wr_bad", wr_bad, 0);
        chk("t4_pos2", rep_pos, 23);
        chk("t4_max2", rep_max, 32'h555);
        end_frame("t4");

        // 5: simultaneous iFace_ready and iEnd -> iEnd wins
        new_test(0, 0, -1, -1);
        om[300] = 32'h42;
        start_frame();
        wait_report("t5", 1);
        chk("t5_pos", rep_pos, 300);
        respond(1'b1, 1'b1);
        tick(30);
        chk("t5_fin_cnt", fin_cnt, 1);
        chk("t5_fin_cyc", fin_cyc, resp_cyc + 1);
        chk("t5_wr_cnt", wr_cnt, 0);
        chk("t5_rep_cnt", rep_cnt, 1);

        // 6: asynchronous reset during the 100th mask write, then a clean restart
        new_test(0, 0, 22, 22);
        om[0]    = 32'hFFFF;
        om[5000] = 32'h77;
        start_frame();
        wait_report("t6a", 1);
        respond(1'b1, 1'b0);
        for (int n = 0; n < 200 && wr_cnt < 99; n++) tick(1);
        chk("t6_reach99", wr_cnt, 99);
        chk("t6_wr_live", {31'd0, oWr_OM}, 1);
        #1 iReset_n = 1'b0;
        #1;
        chk("t6_async_wr", {31'd0, oWr_OM}, 0);
        chk("t6_async_addr", {19'd0, oAddr_OM}, 0);
        chk("t6_async_pos", {19'd0, oPosition}, 0);
        chk("t6_async_max", oMax_val, 0);
        tick(2);
        iReset_n = 1'b1;
        tick(3);
        chk("t6_wr_stop", wr_cnt, 99);
        start_frame();
        chk("t6_scan_a0", {19'd0, oAddr_OM}, 0);
        tick(1);
        chk("t6_scan_a1", {19'd0, oAddr_OM}, 1);
        wait_report("t6b", 2);
        chk("t6_pos", rep_pos, 5000);
        chk("t6_max", rep_max, 32'h77);
        end_frame("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/max_search_23x23.md
Name: max_search_23x23

Overview:
- Upstream producer for the 23x23 threshold stage.
- Raster-scans the classifier output map (OM), finds the maximum score and its address, then presents position and max to the threshold stage with a one-cycle ready pulse.
- On a face-accepted response, zeroes a square region of OM around the hit and rescans for the next face.
- On an end response, terminates the frame.

Parameters:
- COLS, 81, OM row width in words.
- ROWS, 81, OM row count (COLS*ROWS must be at most 8192).
- MASK_W, 23, width of the zeroed region in columns.
- MASK_H, 23, height of the zeroed region in rows.
- MAX_FACES, 16, maximum reports per frame.
- RD_LAT, 1, OM read latency in cycles, from address to iData_from_OM valid.

Ports:
- iClk  in  1  clock.
- iReset_n  in  1  asynchronous active-low reset.
- iStart  in  1  one-cycle frame start; honoured only in IDLE.
- iData_from_OM  in  32  OM read data, unsigned.
- iFace_ready  in  1  threshold stage accepted a face (its output-ready pulse).
- iEnd  in  1  threshold stage rejected the max; no more faces.
- oAddr_OM  out  13  OM address, shared by reads and writes.
- oWr_OM  out  1  OM write enable.
- oData_to_OM  out  32  OM write data; always 0.
- oPosition  out  13  address of the current maximum.
- oMax_val  out  32  current maximum value.
- oOutput_ready  out  1  one-cycle valid for oPosition and oMax_val.
- oFinish  out  1  one-cycle frame-done pulse; also used as the threshold stage's clear.

Behaviour:
- Reset (asynchronous, active low):
  - All outputs 0; state IDLE; face counter 0.
  - Reset mid-scan or mid-mask aborts immediately. No further writes occur; a partially masked OM is left as is.
- IDLE:
  - iStart=1 -> SCAN.
  - On entry to SCAN: addr=0, row=0, col=0, max=0, max_addr=0.
- SCAN:
  - Issues one read per cycle, oAddr_OM = 0 .. COLS*ROWS-1.
  - row/col counters track the address; col wraps at COLS-1 and increments row.
  - Data returned RD_LAT cycles later is compared with max.
  - Strictly greater replaces max and latches max_addr, max_row, max_col. Ties keep the lowest address.
  - An all-zero map yields max=0, max_addr=0.
  - After the last address is issued -> DRAIN.
- DRAIN:
  - Waits RD_LAT cycles so the last compares complete, then -> REPORT.
- REPORT:
  - oPosition=max_addr, oMax_val=max, oOutput_ready=1 for exactly one cycle.
  - oPosition and oMax_val hold until the next REPORT.
  - Next state WAIT.
- WAIT:
  - iEnd=1 -> DONE.
  - iFace_ready=1 -> increment face counter; if the counter reaches MAX_FACES -> DONE, else -> MASK.
  - If both are asserted in the same cycle, iEnd wins.
  - Responses arriving in any other state are ignored.
- MASK:
  - Writes 0 over rows max_row .. max_row+MASK_H-1 and cols max_col .. max_col+MASK_W-1, anchored at the top-left.
  - One write per cycle (oWr_OM=1), row-major order.
  - Cells with col >= COLS or row >= ROWS are skipped. No write is issued and no cycle is spent on them, so there is no wrap into the next row.
  - Address = row*COLS + col, computed incrementally with no multiplier.
  - After the last write -> SCAN (full rescan, max reset to 0).
- DONE:
  - oFinish=1 for one cycle, face counter cleared, -> IDLE.
- Address width rules:
  - All address arithmetic is 13 bits.
  - The max_addr + 162 done downstream is the threshold stage's concern; no range guard is applied here.
- Miscellaneous:
  - oWr_OM is 0 in every state except MASK.
  - iStart outside IDLE is ignored.

Decomposition:
- Shared package: state encoding (IDLE, SCAN, DRAIN, REPORT, WAIT, MASK, DONE), OM address width 13, OM data width 32, COLS/ROWS defaults.
- One natural sub-module, om_mask_walker: given anchor row/col, generates the clipped row-major write addresses with a start/done handshake.

Test Plan:
1. OM all zeros except addr 500 = 32'h0500_0000; start -> one oOutput_ready with oPosition=500, oMax_val=32'h0500_0000, first cycle after 6561 reads + RD_LAT; respond iEnd -> oFinish pulse, no writes.
2. Equal max 32'h100 at addrs 10 and 4000 -> oPosition=10.
3. Max at row 70, col 75 (addr 5745), respond iFace_ready -> writes only rows 70..80, cols 75..80 (66 writes), none to col 0 of the next row; then rescan reports the second-highest value.
4. Max at addr 0 with iFace_ready -> 529 zero writes covering rows 0..22, cols 0..22; the next report excludes that region.
5. iFace_ready and iEnd asserted together in WAIT -> DONE, no mask writes, oFinish one cycle later.
6. Assert iReset_n=0 during MASK write 100 -> all outputs 0 asynchronously, oWr_OM drops same cycle; iStart after release begins a clean scan at addr 0.
